regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter REG_FILE_DEPTH, default 32, number of registers; always 2**REG_DIR_WIDTH.
REQ-003 SHALL have parameter REG_DIR_WIDTH, default 5, register address width.
REQ-004 SHALL have parameter BYPASS, default 1, enabling write-to-read forwarding (1) or disabling it (0).
REQ-005 SHALL have port clk, input, 1, clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have ports readr1, readr2, input, REG_DIR_WIDTH, read addresses.
REQ-008 SHALL have ports rden1, rden2, input, 1, the read port is a true source operand for hazard checking.
REQ-009 SHALL have ports readd1, readd2, output, REG_WIDTH, read data; combinational.
REQ-010 SHALL have ports writer, writedata, RegWrite, input, REG_DIR_WIDTH/REG_WIDTH/1, writeback port.
REQ-011 SHALL have ports issue_valid, input, 1, and issue_dest, input, REG_DIR_WIDTH, which reserve a destination register.
REQ-012 SHALL have port stall, output, 1, hazard indication; combinational.
REQ-013 SHALL have port busy_count, output, REG_DIR_WIDTH+1, number of reserved registers; registered.
REQ-014 SHALL have port wb_err, output, 1, sticky flag for writeback to an unreserved register.

Function
REQ-015 Register 0 SHALL always read 0, ignore writes, never become busy and never cause a stall.
REQ-016 With RegWrite=1 and writer!=0, RegFile[writer] SHALL take writedata at the clock edge.
REQ-017 With BYPASS=1, RegWrite=1, writer!=0 and readrN==writer, readdN SHALL equal writedata in the same cycle; with BYPASS=0, readdN SHALL show the old contents until the edge.
REQ-018 Each register SHALL have a busy bit; busy_count SHALL always equal the population count of the busy bits.
REQ-019 A source hazard SHALL exist for port N when rdenN=1, readrN!=0, busy[readrN]=1, and (BYPASS=0 or the register is not being written back this cycle).
REQ-020 A WAW hazard SHALL exist when issue_valid=1, issue_dest!=0, busy[issue_dest]=1, and issue_dest is not being written back this cycle.
REQ-021 stall SHALL equal issue_valid AND (source hazard on port 1 OR port 2 OR WAW hazard).
REQ-022 An issue SHALL be accepted when issue_valid=1 and stall=0; if issue_dest!=0, busy[issue_dest] SHALL be set at that edge.
REQ-023 A writeback (RegWrite=1, writer!=0) SHALL clear busy[writer] at the edge, unless REQ-024 applies.
REQ-024 If the same register is written back and issued in the same cycle, set SHALL win: busy stays 1, data is written, and busy_count is unchanged.
REQ-025 With writeback and issue to different registers in one cycle, busy_count SHALL be unchanged; with issue only it SHALL increment by 1; with writeback of a busy register only it SHALL decrement by 1.
REQ-026 A writeback to a non-busy register other than 0 SHALL still write the data, leave busy_count unchanged, and set wb_err to 1 until reset.
REQ-027 busy_count SHALL never wrap; its maximum is REG_FILE_DEPTH-1, because register 0 is excluded.
REQ-028 When issue_valid=0, stall SHALL be 0 regardless of busy state.

Reset
REQ-029 While rst=1, every RegFile entry, every busy bit, busy_count and wb_err SHALL be 0, independent of clk.
REQ-030 rst asserted mid-operation SHALL discard all reservations immediately; the first edge after release SHALL behave as from power-up.
REQ-031 Immediately after reset, readd1, readd2 and stall SHALL be 0 for any input combination.

Verification
REQ-032 Reset, then write r5=0x1234_5678 (RegWrite=1) and read readr1=5 the next cycle -> readd1=0x1234_5678; writing r0=0xFFFF_FFFF -> readr2=0 gives readd2=0.
REQ-033 Issue dest r3 (busy_count 0->1), then issue_valid=1, rden1=1, readr1=3 -> stall=1; in the cycle of writeback r3=0xAA with BYPASS=1 -> stall=0, readd1=0xAA, busy_count returns to 0.
REQ-034 With r7 busy: issue_valid=1, issue_dest=7, no writeback -> stall=1 (WAW); with a same-cycle writeback of r7 -> no stall, and busy[7] stays 1 with busy_count unchanged.
REQ-035 Writeback to r9 while not busy -> data written, wb_err=1 and held, busy_count unchanged.
REQ-036 Reserve r1..r31 (busy_count=31), then pulse rst mid-cycle -> busy_count=0, wb_err=0, all reads 0 without waiting for a clock edge.
REQ-037 BYPASS=0 instance: same-cycle writeback r4=0x55 with readr1=4, prior value 0 -> readd1=0 before the edge, 0x55 after it; with rden1=1 and r4 busy -> stall=1 in the writeback cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard for an in-order issue stage.
// Reserves destinations on issue, releases them on writeback, and raises stall on RAW/WAW hazards.
module regfile_scoreboard #(
    parameter int REG_WIDTH      = 32,
    parameter int REG_FILE_DEPTH = 32,
    parameter int REG_DIR_WIDTH  = 5,
    parameter int BYPASS         = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REG_DIR_WIDTH-1:0] readr1,
    input  logic [REG_DIR_WIDTH-1:0] readr2,
    input  logic                     rden1,
    input  logic                     rden2,
    output logic [REG_WIDTH-1:0]     readd1,
    output logic [REG_WIDTH-1:0]     readd2,
    input  logic [REG_DIR_WIDTH-1:0] writer,
    input  logic [REG_WIDTH-1:0]     writedata,
    input  logic                     RegWrite,
    input  logic                     issue_valid,
    input  logic [REG_DIR_WIDTH-1:0] issue_dest,
    output logic                     stall,
    output logic [REG_DIR_WIDTH:0]   busy_count,
    output logic                     wb_err
);

    localparam bit BYPASS_EN = (BYPASS != 0);

    logic [REG_FILE_DEPTH-1:0][REG_WIDTH-1:0] regs_q, regs_d;
    logic [REG_FILE_DEPTH-1:0]                busy_q, busy_d;
    logic [REG_DIR_WIDTH:0]                   busy_count_q, busy_count_d;
    logic                                     wb_err_q, wb_err_d;

    logic wb_active;
    logic wb_hits_r1, wb_hits_r2, wb_hits_dest;
    logic src_haz1, src_haz2, waw_haz;
    logic issue_accept;

    // Hazard detection; a writeback landing this cycle resolves the hazard it would clear.
    always_comb begin
        wb_active    = RegWrite && (writer != '0);
        wb_hits_r1   = wb_active && (writer == readr1);
        wb_hits_r2   = wb_active && (writer == readr2);
        wb_hits_dest = wb_active && (writer == issue_dest);

        src_haz1 = rden1 && (readr1 != '0) && busy_q[readr1] && (!BYPASS_EN || !wb_hits_r1);
        src_haz2 = rden2 && (readr2 != '0) && busy_q[readr2] && (!BYPASS_EN || !wb_hits_r2);
        waw_haz  = issue_valid && (issue_dest != '0) && busy_q[issue_dest] && !wb_hits_dest;

        stall        = issue_valid && (src_haz1 || src_haz2 || waw_haz);
        issue_accept = issue_valid && !(src_haz1 || src_haz2 || waw_haz);
    end

    // Reads are forced to zero while reset is held so no forwarded data leaks out.
    always_comb begin
        readd1 = '0;
        readd2 = '0;
        if (!rst && (readr1 != '0)) begin
            readd1 = (BYPASS_EN && wb_hits_r1) ? writedata : regs_q[readr1];
        end
        if (!rst && (readr2 != '0)) begin
            readd2 = (BYPASS_EN && wb_hits_r2) ? writedata : regs_q[readr2];
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wb_active) begin
            regs_d[writer] = writedata;
        end

        // Clear first, then set, so a same-cycle issue of the written register keeps it busy.
        busy_d = busy_q;
        if (wb_active) begin
            busy_d[writer] = 1'b0;
        end
        if (issue_accept && (issue_dest != '0)) begin
            busy_d[issue_dest] = 1'b1;
        end
        busy_d[0] = 1'b0;

        wb_err_d = wb_err_q || (wb_active && !busy_q[writer]);

        busy_count_d = '0;
        for (int i = 1; i < REG_FILE_DEPTH; i++) begin
            busy_count_d = busy_count_d + {{REG_DIR_WIDTH{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q       <= '0;
            busy_q       <= '0;
            busy_count_q <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign busy_count = busy_count_q;
    assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one bypassing and one non-bypassing instance on shared stimulus,
// directed hazard/reset scenarios plus a random write/read phase checked through an expected queue.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  readr1, readr2, writer, issue_dest;
    logic        rden1, rden2, RegWrite, issue_valid;
    logic [31:0] writedata;

    logic [31:0] b_readd1, b_readd2, n_readd1, n_readd2;
    logic        b_stall, n_stall, b_wb_err, n_wb_err;
    logic [5:0]  b_busy_count, n_busy_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mem_m [32];

    regfile_scoreboard #(.REG_WIDTH(32), .REG_FILE_DEPTH(32), .REG_DIR_WIDTH(5), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .readr1(readr1), .readr2(readr2), .rden1(rden1), .rden2(rden2),
        .readd1(b_readd1), .readd2(b_readd2),
        .writer(writer), .writedata(writedata), .RegWrite(RegWrite),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .stall(b_stall), .busy_count(b_busy_count), .wb_err(b_wb_err)
    );

    regfile_scoreboard #(.REG_WIDTH(32), .REG_FILE_DEPTH(32), .REG_DIR_WIDTH(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .readr1(readr1), .readr2(readr2), .rden1(rden1), .rden2(rden2),
        .readd1(n_readd1), .readd2(n_readd2),
        .writer(writer), .writedata(writedata), .RegWrite(RegWrite),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .stall(n_stall), .busy_count(n_busy_count), .wb_err(n_wb_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        readr1 = '0; readr2 = '0; rden1 = 1'b0; rden2 = 1'b0;
        writer = '0; writedata = '0; RegWrite = 1'b0;
        issue_valid = 1'b0; issue_dest = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [4:0] dest);
        issue_valid = 1'b1;
        issue_dest  = dest;
    endtask

    task automatic writeback(input logic [4:0] r, input logic [31:0] d);
        RegWrite  = 1'b1;
        writer    = r;
        writedata = d;
    endtask

    task automatic sb_pop_check(input string tag, input logic [31:0] obs_b, input logic [31:0] obs_n);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_byp"}, obs_b, e);
            check_val({tag, "_nobyp"}, obs_n, e);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;

        // reset held: outputs zero regardless of inputs and clock edges
        #3;
        writeback(5'd5, 32'hCAFE_F00D);
        readr1 = 5'd5; readr2 = 5'd5; rden1 = 1'b1;
        issue(5'd5);
        #1;
        check_val("rst_readd1", b_readd1, 32'h0);
        check_val("rst_readd2_nb", n_readd2, 32'h0);
        check_val("rst_stall", 32'(b_stall), 32'h0);
        tick();
        check_val("rst_busy_count", 32'(b_busy_count), 32'h0);
        check_val("rst_wb_err", 32'(b_wb_err), 32'h0);
        idle();
        rst = 1'b0;
        tick();

        // write r5, bypass vs. no bypass, then r0 write ignored
        writeback(5'd5, 32'h1234_5678);
        readr1 = 5'd5;
        #2;
        check_val("byp_same_cycle", b_readd1, 32'h1234_5678);
        check_val("nobyp_old_value", n_readd1, 32'h0);
        tick();
        writeback(5'd0, 32'hFFFF_FFFF);
        readr1 = 5'd5; readr2 = 5'd0;
        #2;
        check_val("r5_read_byp", b_readd1, 32'h1234_5678);
        check_val("r5_read_nobyp", n_readd1, 32'h1234_5678);
        check_val("r0_no_forward", b_readd2, 32'h0);
        tick();
        idle();
        #1;
        check_val("r0_after_write", b_readd2, 32'h0);
        check_val("wb_err_unreserved_r5", 32'(b_wb_err), 32'h1);
        check_val("count_after_writes", 32'(b_busy_count), 32'h0);
        do_reset();
        check_val("wb_err_cleared", 32'(b_wb_err), 32'h0);

        // RAW on r3 resolved by same-cycle writeback only with bypass
        tick();
        issue(5'd3);
        #1;
        check_val("issue_r3_nostall", 32'(b_stall), 32'h0);
        tick();
        idle();
        #1;
        check_val("count_issue_r3", 32'(b_busy_count), 32'h1);
        issue(5'd10); rden1 = 1'b1; readr1 = 5'd3;
        #1;
        check_val("raw_stall", 32'(b_stall), 32'h1);
        tick();
        check_val("count_held_on_stall", 32'(b_busy_count), 32'h1);
        issue_dest = 5'd0;
        writeback(5'd3, 32'h0000_00AA);
        #1;
        check_val("raw_wb_nostall", 32'(b_stall), 32'h0);
        check_val("raw_wb_data", b_readd1, 32'h0000_00AA);
        check_val("nobyp_raw_wb_stall", 32'(n_stall), 32'h1);
        tick();
        idle();
        #1;
        check_val("count_after_wb_r3", 32'(b_busy_count), 32'h0);
        check_val("count_after_wb_r3_nb", 32'(n_busy_count), 32'h0);
        check_val("wb_err_busy_wb", 32'(b_wb_err), 32'h0);

        // WAW on r7, set wins over same-cycle writeback
        issue(5'd7);
        tick();
        idle();
        #1;
        check_val("count_issue_r7", 32'(b_busy_count), 32'h1);
        issue(5'd7);
        #1;
        check_val("waw_stall", 32'(b_stall), 32'h1);
        check_val("waw_stall_nb", 32'(n_stall), 32'h1);
        tick();
        writeback(5'd7, 32'h0000_0077);
        #1;
        check_val("waw_wb_nostall", 32'(b_stall), 32'h0);
        check_val("waw_wb_nostall_nb", 32'(n_stall), 32'h0);
        tick();
        idle();
        #1;
        check_val("count_set_wins", 32'(b_busy_count), 32'h1);
        check_val("count_set_wins_nb", 32'(n_busy_count), 32'h1);
        issue(5'd0); rden2 = 1'b1; readr2 = 5'd7;
        #1;
        check_val("r7_still_busy", 32'(b_stall), 32'h1);
        check_val("r7_data_written", b_readd2, 32'h0000_0077);
        issue_valid = 1'b0;
        #1;
        check_val("no_issue_no_stall", 32'(b_stall), 32'h0);
        idle();
        writeback(5'd7, 32'h0000_0078);
        tick();
        idle();
        #1;
        check_val("count_after_wb_r7", 32'(b_busy_count), 32'h0);

        // writeback and issue to different registers in one cycle
        issue(5'd2);
        tick();
        issue(5'd4);
        writeback(5'd2, 32'h2);
        #1;
        check_val("diff_wb_issue_nostall", 32'(b_stall), 32'h0);
        tick();
        idle();
        #1;
        check_val("count_wb_issue_diff", 32'(b_busy_count), 32'h1);
        writeback(5'd4, 32'h4);
        tick();
        idle();
        #1;
        check_val("count_after_wb_r4", 32'(b_busy_count), 32'h0);
        check_val("wb_err_still_clean", 32'(b_wb_err), 32'h0);

        // writeback to a register that was never reserved
        writeback(5'd9, 32'h0000_DEAD);
        tick();
        idle();
        readr1 = 5'd9;
        #1;
        check_val("wb_err_set", 32'(b_wb_err), 32'h1);
        check_val("count_unreserved_wb", 32'(b_busy_count), 32'h0);
        check_val("r9_written", b_readd1, 32'h0000_DEAD);
        tick();
        check_val("wb_err_sticky", 32'(b_wb_err), 32'h1);

        // reserve r1..r31, r0 never counted
        for (int r = 1; r < 32; r++) begin
            issue(5'(r));
            tick();
        end
        idle();
        #1;
        check_val("count_full", 32'(b_busy_count), 32'd31);
        issue(5'd0); rden1 = 1'b1; readr1 = 5'd0;
        #1;
        check_val("r0_never_stalls", 32'(b_stall), 32'h0);
        tick();
        check_val("count_no_wrap", 32'(b_busy_count), 32'd31);
        issue(5'd9);
        #1;
        check_val("full_waw_stall", 32'(b_stall), 32'h1);

        // asynchronous reset mid-cycle
        idle();
        readr1 = 5'd9; readr2 = 5'd7;
        rst = 1'b1;
        #1;
        check_val("midrst_count", 32'(b_busy_count), 32'h0);
        check_val("midrst_count_nb", 32'(n_busy_count), 32'h0);
        check_val("midrst_wb_err", 32'(b_wb_err), 32'h0);
        check_val("midrst_read1", b_readd1, 32'h0);
        check_val("midrst_read2", b_readd2, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check_val("postrst_read1", b_readd1, 32'h0);
        issue(5'd9); rden1 = 1'b1;
        #1;
        check_val("postrst_nostall", 32'(b_stall), 32'h0);
        idle();

        // non-bypass instance: old data until the edge, stall through writeback cycle
        tick();
        writeback(5'd4, 32'h0000_0055);
        readr1 = 5'd4;
        #1;
        check_val("nobyp_before_edge", n_readd1, 32'h0);
        check_val("byp_before_edge", b_readd1, 32'h0000_0055);
        tick();
        idle();
        readr1 = 5'd4;
        #1;
        check_val("nobyp_after_edge", n_readd1, 32'h0000_0055);
        issue(5'd4);
        tick();
        idle();
        issue(5'd0); rden1 = 1'b1; readr1 = 5'd4;
        writeback(5'd4, 32'h0000_0066);
        #1;
        check_val("nobyp_wb_cycle_stall", 32'(n_stall), 32'h1);
        check_val("nobyp_wb_cycle_old", n_readd1, 32'h0000_0055);
        check_val("byp_wb_cycle_nostall", 32'(b_stall), 32'h0);
        tick();
        idle();

        // random writes, each followed by a read of a random register
        do_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        for (int it = 0; it < 40; it++) begin
            logic [4:0]  w, ra;
            logic [31:0] d;
            w  = 5'($urandom_range(0, 31));
            ra = 5'($urandom_range(0, 31));
            d  = $urandom;
            writeback(w, d);
            if (w != 5'd0) mem_m[w] = d;
            exp_q.push_back(mem_m[ra]);
            tick();
            idle();
            readr2 = ra;
            #1;
            sb_pop_check("rand_read", b_readd2, n_readd2);
        end
        check_val("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
